sauria_tile_writer: RTL and testbench

Hardware producer for SAURIA output-tile SRAM. It accepts a row-major stream of signed 32-bit result elements for one 16×16 matrix and packs them four per 128-bit line. It writes each line into output SRAM at the line address used by result-checking software and benches: matrix m occupies lines m*64 … m*64+63, element (row, col) sits in line m*64 + row*4 + col/4, word lane col%4, with lane 0 at bits [31:0]. It sits between the array output drain and the SRAM write port.

---
 rtl/sauria_tile_writer.sv | 172 +++++++++++++++++
 tb/tb_sauria_tile_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sauria_tile_writer.sv
// Packs a row-major stream of WORD_W elements into WORDS_PER_LINE-wide SRAM lines for one matrix slot.
// Optional per-matrix checksum output enabled by defining SAURIA_TILE_WR_CHKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start_i; out-of-range slot pulses err_o
// FILL    | accepting elements into the line register
// WRITE   | line presented to SRAM until sram_gnt_i
// DONE    | one-cycle done_o pulse
module sauria_tile_writer #(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_MATS       = 8,
    parameter int ADDR_W         = 9
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [7:0]                       mat_idx_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    input  logic [WORD_W-1:0]                s_data_i,
    output logic                             sram_req_o,
    output logic                             sram_we_o,
    output logic [ADDR_W-1:0]                sram_addr_o,
    output logic [WORD_W*WORDS_PER_LINE-1:0] sram_wdata_o,
    input  logic                             sram_gnt_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o
`ifdef SAURIA_TILE_WR_CHKSUM_EN
    ,
    output logic [WORD_W-1:0]                chksum_o
`endif
);

    localparam int LINES_PER_MAT = ROWS * COLS / WORDS_PER_LINE;
    localparam int LANE_W        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LINE_W        = (LINES_PER_MAT > 1) ? $clog2(LINES_PER_MAT) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_MAT - 1);

    if (COLS % WORDS_PER_LINE != 0) begin : g_bad_cols
        $error("COLS must be a multiple of WORDS_PER_LINE");
    end
    if ((64'd1 << ADDR_W) < 64'(NUM_MATS * LINES_PER_MAT)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for NUM_MATS matrices");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]                r_base;
    logic [LANE_W-1:0]                r_lane;
    logic [LINE_W-1:0]                r_line_cnt;
    logic [WORD_W*WORDS_PER_LINE-1:0] r_line;
    logic                             r_err;

    logic [31:0]       w_idx32;
    logic              w_in_range;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_hs;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_base;

    assign w_idx32     = 32'(mat_idx_i);
    assign w_in_range  = (w_idx32 < 32'(NUM_MATS));
    assign w_start_ok  = (r_state == S_IDLE) && start_i && w_in_range;
    assign w_start_bad = (r_state == S_IDLE) && start_i && !w_in_range;
    assign w_hs        = (r_state == S_FILL) && s_valid_i;
    assign w_gnt       = (r_state == S_WRITE) && sram_gnt_i;
    assign w_base      = ADDR_W'(w_idx32 * 32'(LINES_PER_MAT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        s_ready_o  = 1'b0;
        sram_req_o = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (w_start_ok) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                s_ready_o = 1'b1;
                if (w_hs && (r_lane == LAST_LANE)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                sram_req_o = 1'b1;
                if (sram_gnt_i) begin
                    w_next = (r_line_cnt == LAST_LINE) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Reset clears the line register so a partially filled line never reaches SRAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_lane     <= '0;
            r_line_cnt <= '0;
            r_line     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_base     <= w_base;
                r_lane     <= '0;
                r_line_cnt <= '0;
            end
            if (w_hs) begin
                r_line[r_lane*WORD_W +: WORD_W] <= s_data_i;
                r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + LANE_W'(1);
            end
            if (w_gnt && (r_line_cnt != LAST_LINE)) begin
                r_line_cnt <= r_line_cnt + LINE_W'(1);
            end
        end
    end

    assign sram_we_o    = sram_req_o;
    assign sram_addr_o  = r_base + ADDR_W'(r_line_cnt);
    assign sram_wdata_o = r_line;
    assign err_o        = r_err;

`ifdef SAURIA_TILE_WR_CHKSUM_EN
    logic [WORD_W-1:0] r_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sum <= '0;
        end else if (w_start_ok) begin
            r_sum <= '0;
        end else if (w_hs) begin
            r_sum <= r_sum + s_data_i;
        end
    end

    assign chksum_o = r_sum;
`endif

endmodule

// File: tb/tb_sauria_tile_writer.sv
// Directed bench for sauria_tile_writer: packing, addressing, stalls, error start, reset and ignored start.
module tb_sauria_tile_writer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [7:0]   mat_idx_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [31:0]  s_data_i;
    logic         sram_req_o;
    logic         sram_we_o;
    logic [8:0]   sram_addr_o;
    logic [127:0] sram_wdata_o;
    logic         sram_gnt_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
`ifdef SAURIA_TILE_WR_CHKSUM_EN
    logic [31:0]  chksum_o;
`endif

    sauria_tile_writer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .mat_idx_i    (mat_idx_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_gnt_i   (sram_gnt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
`ifdef SAURIA_TILE_WR_CHKSUM_EN
        ,
        .chksum_o     (chksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    logic [127:0] mem [0:511];
    int wr_cnt  = 0;
    int oob_cnt = 0;
    int lo_ok   = 0;
    int hi_ok   = 511;
    int total   = 0;
    int bad     = 0;

    always @(posedge clk_i) begin
        if (sram_req_o && sram_gnt_i) begin
            mem[sram_addr_o] = sram_wdata_o;
            wr_cnt++;
            if (int'(sram_addr_o) < lo_ok || int'(sram_addr_o) > hi_ok) oob_cnt++;
        end
    end

    function automatic logic [127:0] ramp(input int k);
        return {32'(k + 3), 32'(k + 2), 32'(k + 1), 32'(k)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] idx);
        start_i   = 1'b1;
        mat_idx_i = idx;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    // Offers n elements starting at value k0 (or all-ones); called and returns at a negedge.
    task automatic feed(input int k0, input int n, input bit ones, output int iters);
        int k;
        bit hs;
        k = 0;
        iters = 0;
        s_valid_i = 1'b1;
        while (k < n && iters < 3000) begin
            s_data_i = ones ? 32'hFFFF_FFFF : 32'(k0 + k);
            hs = s_ready_o;
            @(negedge clk_i);
            iters++;
            if (hs) k++;
        end
        s_valid_i = 1'b0;
        chk("feed_count", 128'(k), 128'(n));
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("done_seen", 128'(done_o), 128'd1);
        @(negedge clk_i);
        chk("done_one_cycle", 128'(done_o), 128'd0);
        chk("idle_after_done", 128'(busy_o), 128'd0);
    endtask

    initial begin
        int it;
        int w0;
        int good;
        logic [8:0]   hold_addr;
        logic [127:0] hold_data;

        rst_i      = 1'b1;
        start_i    = 1'b0;
        mat_idx_i  = '0;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        sram_gnt_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 128'(s_ready_o), 128'd0);
        chk("rst_req", 128'(sram_req_o), 128'd0);
        chk("rst_addr", 128'(sram_addr_o), 128'd0);
        chk("rst_wdata", sram_wdata_o, 128'd0);
        chk("rst_busy_done_err", 128'({busy_o, done_o, err_o}), 128'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // matrix 0, ramp 0..255, grant always high
        lo_ok = 0; hi_ok = 63; w0 = wr_cnt;
        do_start(8'd0);
        chk("start_busy", 128'(busy_o), 128'd1);
        chk("start_ready", 128'(s_ready_o), 128'd1);
        feed(0, 256, 1'b0, it);
        chk("m0_cycles_to_last_write", 128'(it), 128'd319);
        chk("m0_last_req", 128'(sram_req_o), 128'd1);
        chk("m0_we_eq_req", 128'(sram_we_o), 128'd1);
        chk("m0_last_addr", 128'(sram_addr_o), 128'd63);
        @(negedge clk_i);
        chk("m0_done_at_320", 128'(done_o), 128'd1);
`ifdef SAURIA_TILE_WR_CHKSUM_EN
        chk("m0_chksum", 128'(chksum_o), 128'd32640);
`endif
        @(negedge clk_i);
        chk("m0_done_pulse", 128'(done_o), 128'd0);
        chk("m0_idle", 128'(busy_o), 128'd0);
        chk("m0_writes", 128'(wr_cnt - w0), 128'd64);
        chk("m0_line0", mem[0], 128'h00000003_00000002_00000001_00000000);
        chk("m0_line63", mem[63], ramp(252));
        good = 0;
        for (int l = 0; l < 64; l++) if (mem[l] === ramp(4 * l)) good++;
        chk("m0_all_lines", 128'(good), 128'd64);

        // matrix 7, all -1
        lo_ok = 448; hi_ok = 511; w0 = wr_cnt;
        do_start(8'd7);
        feed(0, 256, 1'b1, it);
        wait_done();
        chk("m7_writes", 128'(wr_cnt - w0), 128'd64);
        good = 0;
        for (int l = 448; l < 512; l++) if (mem[l] === {128{1'b1}}) good++;
        chk("m7_all_ones", 128'(good), 128'd64);
`ifdef SAURIA_TILE_WR_CHKSUM_EN
        chk("m7_chksum", 128'(chksum_o), 128'hFFFF_FF00);
`endif

        // matrix 1, grant withheld 10 cycles on line 5
        lo_ok = 64; hi_ok = 127; w0 = wr_cnt;
        do_start(8'd1);
        feed(0, 20, 1'b0, it);
        @(negedge clk_i);
        sram_gnt_i = 1'b0;
        feed(20, 4, 1'b0, it);
        hold_addr = sram_addr_o;
        hold_data = sram_wdata_o;
        chk("stall_addr", 128'(hold_addr), 128'd69);
        chk("stall_wdata", hold_data, ramp(20));
        good = 0;
        for (int c = 0; c < 10; c++) begin
            if (sram_req_o && !s_ready_o && sram_addr_o === hold_addr && sram_wdata_o === hold_data) good++;
            @(negedge clk_i);
        end
        chk("stall_stable_cycles", 128'(good), 128'd10);
        chk("stall_no_write", 128'(wr_cnt - w0), 128'd5);
        sram_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("stall_one_write", 128'(wr_cnt - w0), 128'd6);
        chk("stall_line", mem[69], ramp(20));
        feed(24, 232, 1'b0, it);
        wait_done();
        chk("m1_writes", 128'(wr_cnt - w0), 128'd64);
        chk("m1_line127", mem[127], ramp(252));

        // out-of-range slot
        w0 = wr_cnt;
        do_start(8'd8);
        chk("err_pulse", 128'(err_o), 128'd1);
        chk("err_busy", 128'(busy_o), 128'd0);
        chk("err_req", 128'(sram_req_o), 128'd0);
        @(negedge clk_i);
        chk("err_one_cycle", 128'(err_o), 128'd0);
        chk("err_still_idle", 128'(busy_o), 128'd0);
        chk("err_no_write", 128'(wr_cnt - w0), 128'd0);

        // reset after 6 elements of matrix 2
        lo_ok = 128; hi_ok = 128; w0 = wr_cnt;
        do_start(8'd2);
        feed(0, 6, 1'b0, it);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mrst_ready", 128'(s_ready_o), 128'd0);
        chk("mrst_req", 128'(sram_req_o), 128'd0);
        chk("mrst_addr", 128'(sram_addr_o), 128'd0);
        chk("mrst_wdata", sram_wdata_o, 128'd0);
        chk("mrst_busy_done_err", 128'({busy_o, done_o, err_o}), 128'd0);
        repeat (5) @(negedge clk_i);
        chk("mrst_writes", 128'(wr_cnt - w0), 128'd1);
        chk("mrst_line128", mem[128], ramp(0));
        lo_ok = 128; hi_ok = 191; w0 = wr_cnt;
        do_start(8'd2);
        feed(1000, 256, 1'b0, it);
        wait_done();
        chk("m2_writes", 128'(wr_cnt - w0), 128'd64);
        chk("m2_line128", mem[128], ramp(1000));
        chk("m2_line191", mem[191], ramp(1252));

        // start during FILL is ignored
        lo_ok = 192; hi_ok = 255; w0 = wr_cnt;
        do_start(8'd3);
        feed(0, 10, 1'b0, it);
        do_start(8'd5);
        chk("ign_no_err", 128'(err_o), 128'd0);
        chk("ign_still_fill", 128'(s_ready_o), 128'd1);
        feed(10, 246, 1'b0, it);
        wait_done();
        chk("m3_writes", 128'(wr_cnt - w0), 128'd64);
        chk("m3_line194", mem[194], ramp(8));
        chk("m3_line255", mem[255], ramp(252));
`ifdef SAURIA_TILE_WR_CHKSUM_EN
        chk("m3_chksum", 128'(chksum_o), 128'd32640);
`endif

        chk("no_out_of_range_writes", 128'(oob_cnt), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
